// File: rtl/call_stack_ctrl.sv
//==============================================================================
// Module      : call_stack_ctrl
// Description : Call-stack pointer/sequencer driving a single-port synchronous
//               stack memory. Optional top-of-stack cache: FSTACK_TOS_CACHE_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module call_stack_ctrl #(
    parameter int IA_WIDTH   = 12,
    parameter int D_WIDTH    = 34,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n_i,
    input  logic                  push_i,
    input  logic [IA_WIDTH-1:0]   push_addr_i,
    input  logic                  pop_i,
    input  logic                  clear_i,
    output logic                  ready_o,
    output logic [IA_WIDTH-1:0]   ret_addr_o,
    output logic                  ret_valid_o,
    output logic [DEPTH_LOG2:0]   depth_o,
    output logic                  overflow_o,
    output logic                  underflow_o,
    output logic                  mem_we_o,
    output logic [DEPTH_LOG2-1:0] mem_addr_o,
    output logic [D_WIDTH-1:0]    mem_din_o,
    input  logic [D_WIDTH-1:0]    mem_dout_i
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_POP_WAIT = 2'd1,
        S_ERR      = 2'd2,
        S_REFILL   = 2'd3
    } state_t;

    localparam logic [DEPTH_LOG2:0]   c_FULL   = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   c_SP_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] c_A_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    state_t                r_state, w_state_nxt;
    logic [DEPTH_LOG2:0]   r_sp, w_sp_nxt;
    logic                  r_ovf, r_unf;
    logic [IA_WIDTH-1:0]   r_ret_addr;
    logic                  r_ret_valid;
    logic                  w_empty, w_full;
    logic [DEPTH_LOG2-1:0] w_top;
    logic                  w_we;
    logic [DEPTH_LOG2-1:0] w_addr;
    logic                  w_set_ovf, w_set_unf, w_clr;
    logic                  w_unused;

`ifdef FSTACK_TOS_CACHE_EN
    logic [IA_WIDTH-1:0]   r_tos;
    logic                  w_pop_go;
    logic [DEPTH_LOG2-1:0] w_below;
    assign w_below = w_top - c_A_ONE;
`endif

    assign w_empty  = (r_sp == '0);
    assign w_full   = (r_sp == c_FULL);
    // Low bits of sp-1 wrap correctly even when sp == 2^DEPTH_LOG2.
    assign w_top    = r_sp[DEPTH_LOG2-1:0] - c_A_ONE;
    assign w_unused = ^mem_dout_i[D_WIDTH-1:IA_WIDTH];

    always_comb begin
        w_state_nxt = r_state;
        w_sp_nxt    = r_sp;
        w_we        = 1'b0;
        w_addr      = r_sp[DEPTH_LOG2-1:0];
        w_set_ovf   = 1'b0;
        w_set_unf   = 1'b0;
        w_clr       = 1'b0;
`ifdef FSTACK_TOS_CACHE_EN
        w_pop_go    = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (pop_i) begin
                    if (w_empty) begin
                        w_set_unf   = 1'b1;
                        w_state_nxt = S_ERR;
                    end else if (push_i) begin
                        // Tail call: replace the top entry in place.
                        w_we   = 1'b1;
                        w_addr = w_top;
                    end else begin
                        w_sp_nxt = r_sp - c_SP_ONE;
`ifdef FSTACK_TOS_CACHE_EN
                        // Prefetch the new top so REFILL can latch it.
                        w_pop_go    = 1'b1;
                        w_addr      = w_below;
                        w_state_nxt = (w_sp_nxt == '0) ? S_IDLE : S_REFILL;
`else
                        w_addr      = w_top;
                        w_state_nxt = S_POP_WAIT;
`endif
                    end
                end else if (push_i) begin
                    if (w_full) begin
                        w_set_ovf   = 1'b1;
                        w_state_nxt = S_ERR;
                    end else begin
                        w_we     = 1'b1;
                        w_sp_nxt = r_sp + c_SP_ONE;
                    end
                end
            end
            S_POP_WAIT: w_state_nxt = S_IDLE;
            S_ERR: begin
                if (clear_i) begin
                    w_clr       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= S_IDLE;
            r_sp        <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_ret_addr  <= '0;
            r_ret_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sp    <= w_sp_nxt;
            if (w_clr) begin
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
            end else begin
                if (w_set_ovf) r_ovf <= 1'b1;
                if (w_set_unf) r_unf <= 1'b1;
            end
`ifdef FSTACK_TOS_CACHE_EN
            r_ret_valid <= w_pop_go;
            if (w_pop_go) r_ret_addr <= r_tos;
`else
            r_ret_valid <= (r_state == S_POP_WAIT);
            if (r_state == S_POP_WAIT) r_ret_addr <= mem_dout_i[IA_WIDTH-1:0];
`endif
        end
    end

`ifdef FSTACK_TOS_CACHE_EN
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_tos <= '0;
        end else if (w_we) begin
            r_tos <= push_addr_i;
        end else if (r_state == S_REFILL) begin
            r_tos <= mem_dout_i[IA_WIDTH-1:0];
        end
    end
`endif

    assign ready_o     = (r_state == S_IDLE);
    assign ret_addr_o  = r_ret_addr;
    assign ret_valid_o = r_ret_valid;
    assign depth_o     = r_sp;
    assign overflow_o  = r_ovf;
    assign underflow_o = r_unf;
    assign mem_we_o    = w_we;
    assign mem_addr_o  = w_addr;
    assign mem_din_o   = {{(D_WIDTH-IA_WIDTH){1'b0}}, push_addr_i};

endmodule

`default_nettype wire

// File: tb/tb_call_stack_ctrl.sv
//==============================================================================
// Module      : tb_call_stack_ctrl
// Description : Randomized self-checking bench for call_stack_ctrl against a
//               queue-based stack model and a behavioural stack memory.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_call_stack_ctrl;

    localparam int IA_WIDTH   = 12;
    localparam int D_WIDTH    = 34;
    localparam int DEPTH_LOG2 = 4;
    localparam int N_ENT      = 16;
`ifdef FSTACK_TOS_CACHE_EN
    localparam int RET_LAT    = 1;
`else
    localparam int RET_LAT    = 2;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n_i = 1'b0;
    logic                  push_i = 1'b0;
    logic [IA_WIDTH-1:0]   push_addr_i = '0;
    logic                  pop_i = 1'b0;
    logic                  clear_i = 1'b0;
    logic                  ready_o;
    logic [IA_WIDTH-1:0]   ret_addr_o;
    logic                  ret_valid_o;
    logic [DEPTH_LOG2:0]   depth_o;
    logic                  overflow_o;
    logic                  underflow_o;
    logic                  mem_we_o;
    logic [DEPTH_LOG2-1:0] mem_addr_o;
    logic [D_WIDTH-1:0]    mem_din_o;
    logic [D_WIDTH-1:0]    mem_dout_i;

    call_stack_ctrl #(
        .IA_WIDTH   (IA_WIDTH),
        .D_WIDTH    (D_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) dut (
        .clk         (clk),
        .rst_n_i     (rst_n_i),
        .push_i      (push_i),
        .push_addr_i (push_addr_i),
        .pop_i       (pop_i),
        .clear_i     (clear_i),
        .ready_o     (ready_o),
        .ret_addr_o  (ret_addr_o),
        .ret_valid_o (ret_valid_o),
        .depth_o     (depth_o),
        .overflow_o  (overflow_o),
        .underflow_o (underflow_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_din_o   (mem_din_o),
        .mem_dout_i  (mem_dout_i)
    );

    always #5 clk = ~clk;

    // Single-port synchronous memory, read-before-write, never reset.
    logic [D_WIDTH-1:0] mem [N_ENT];
    initial begin
        for (int i = 0; i < N_ENT; i++) mem[i] = '0;
        mem_dout_i = '0;
    end
    always @(posedge clk) begin
        mem_dout_i <= mem[mem_addr_o];
        if (mem_we_o) mem[mem_addr_o] <= mem_din_o;
    end

    // Reference model
    logic [IA_WIDTH-1:0] q[$];
    logic [IA_WIDTH-1:0] ret_log[$];
    logic [IA_WIDTH-1:0] m_ret_addr, m_ret_pend;
    bit                  m_err, m_ovf, m_unf;
    int                  m_busy, m_cd;
    int                  n_cmp = 0;
    int                  n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return !m_err && (m_busy == 0);
    endfunction

    task automatic model_reset();
        q.delete();
        m_err = 0; m_ovf = 0; m_unf = 0;
        m_busy = 0; m_cd = 0;
        m_ret_addr = '0; m_ret_pend = '0;
    endtask

    task automatic check_state();
        chk("ready", ready_o, m_ready());
        chk("depth", depth_o, q.size());
        chk("ret_valid", ret_valid_o, m_cd == 1);
        chk("ret_addr", ret_addr_o, m_ret_addr);
        chk("overflow", overflow_o, m_ovf);
        chk("underflow", underflow_o, m_unf);
        for (int i = 0; i < q.size(); i++)
            chk($sformatf("mem[%0d]", i), mem[i], {{(D_WIDTH-IA_WIDTH){1'b0}}, q[i]});
        if (ret_valid_o === 1'b1) ret_log.push_back(ret_addr_o);
    endtask

    task automatic check_mem_if(input bit p, input logic [IA_WIDTH-1:0] a, input bit o);
        bit exp_we;
        exp_we = m_ready() && p && (o ? (q.size() > 0) : (q.size() < N_ENT));
        chk("mem_we", mem_we_o, exp_we);
        if (exp_we) begin
            chk("mem_addr", mem_addr_o, o ? q.size() - 1 : q.size());
            chk("mem_din", mem_din_o, {{(D_WIDTH-IA_WIDTH){1'b0}}, a});
        end
    endtask

    task automatic model_edge(input bit p, input logic [IA_WIDTH-1:0] a, input bit o, input bit c);
        bit rdy;
        rdy = m_ready();
        if (m_cd > 0) m_cd--;
        if (m_busy > 0) m_busy--;
        if (m_err) begin
            if (c) begin m_err = 0; m_ovf = 0; m_unf = 0; end
        end else if (rdy) begin
            if (o) begin
                if (q.size() == 0) begin
                    m_unf = 1; m_err = 1;
                end else if (p) begin
                    q[q.size()-1] = a;
                end else begin
                    m_ret_pend = q.pop_back();
                    m_cd = RET_LAT;
                    m_busy = (RET_LAT == 2 || q.size() > 0) ? 1 : 0;
                end
            end else if (p) begin
                if (q.size() == N_ENT) begin
                    m_ovf = 1; m_err = 1;
                end else begin
                    q.push_back(a);
                end
            end
        end
        if (m_cd == 1) m_ret_addr = m_ret_pend;
    endtask

    // Entered and left at a negedge: drive, check, clock, update model.
    task automatic cycle(input bit p, input logic [IA_WIDTH-1:0] a, input bit o, input bit c);
        push_i = p; push_addr_i = a; pop_i = o; clear_i = c;
        #1;
        check_state();
        check_mem_if(p, a, o);
        @(posedge clk);
        model_edge(p, a, o, c);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, '0, 0, 0);
    endtask

    // Asynchronous reset asserted mid-cycle, held across one rising edge.
    task automatic do_reset();
        push_i = 0; pop_i = 0; clear_i = 0; push_addr_i = '0;
        rst_n_i = 1'b0;
        model_reset();
        #1;
        chk("rst_ready", ready_o, 1);
        chk("rst_depth", depth_o, 0);
        chk("rst_ret_valid", ret_valid_o, 0);
        chk("rst_ret_addr", ret_addr_o, 0);
        chk("rst_flags", {overflow_o, underflow_o}, 0);
        chk("rst_mem_we", mem_we_o, 0);
        @(negedge clk);
        rst_n_i = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // Three consecutive pushes, then two pops at legal spacing.
        ret_log.delete();
        cycle(1, 12'h123, 0, 0);
        cycle(1, 12'h456, 0, 0);
        cycle(1, 12'h789, 0, 0);
        chk("lit_depth3", depth_o, 3);
        chk("lit_mem0", mem[0], 34'h123);
        chk("lit_mem2", mem[2], 34'h789);
        chk("lit_no_ret", ret_log.size(), 0);
        cycle(0, '0, 1, 0);
        idle(1);
        cycle(0, '0, 1, 0);
        idle(3);
        chk("lit_depth1", depth_o, 1);
        chk("lit_nret", ret_log.size(), 2);
        if (ret_log.size() == 2) begin
            chk("lit_ret0", ret_log[0], 12'h789);
            chk("lit_ret1", ret_log[1], 12'h456);
        end

        // Fill to 16, then overflow.
        do_reset();
        for (int i = 0; i < N_ENT; i++) cycle(1, 12'(i * 17 + 1), 0, 0);
        cycle(1, 12'hABC, 0, 0);
        chk("lit_ovf", overflow_o, 1);
        chk("lit_ovf_ready", ready_o, 0);
        chk("lit_ovf_depth", depth_o, 16);
        chk("lit_mem15", mem[15], 34'(15 * 17 + 1));
        cycle(1, 12'h111, 1, 0);
        cycle(0, '0, 0, 1);
        chk("lit_clr_ready", ready_o, 1);
        chk("lit_clr_ovf", overflow_o, 0);

        // Underflow, pushes ignored until clear.
        do_reset();
        ret_log.delete();
        cycle(0, '0, 1, 0);
        chk("lit_unf", underflow_o, 1);
        cycle(1, 12'h055, 0, 0);
        cycle(1, 12'h066, 0, 0);
        chk("lit_unf_depth", depth_o, 0);
        chk("lit_unf_noret", ret_log.size(), 0);
        cycle(0, '0, 0, 1);
        idle(1);

        // Tail call over depth 2.
        do_reset();
        ret_log.delete();
        cycle(1, 12'h010, 0, 0);
        cycle(1, 12'h020, 0, 0);
        cycle(1, 12'h0FF, 1, 0);
        chk("lit_tail_depth", depth_o, 2);
        cycle(0, '0, 1, 0);
        idle(1);
        cycle(0, '0, 1, 0);
        idle(3);
        chk("lit_tail_n", ret_log.size(), 2);
        if (ret_log.size() == 2) begin
            chk("lit_tail0", ret_log[0], 12'h0FF);
            chk("lit_tail1", ret_log[1], 12'h010);
        end

        // Reset while a return is pending.
        do_reset();
        ret_log.delete();
        cycle(1, 12'h321, 0, 0);
        cycle(1, 12'h654, 0, 0);
        cycle(0, '0, 1, 0);
        do_reset();
        chk("lit_midrst_ready", ready_o, 1);
        chk("lit_midrst_depth", depth_o, 0);
        idle(4);
        chk("lit_midrst_noret", ret_log.size(), 0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            int r;
            bit p, o, c;
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                r = $urandom_range(0, 99);
                p = (r < 40) || (r >= 65 && r < 75);
                o = (r >= 40 && r < 75);
                c = ($urandom_range(0, 9) < 3);
                cycle(p, 12'($urandom_range(0, 4095)), o, c);
            end
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/call_stack_ctrl.md
# call_stack_ctrl

Controller for the processor's function call stack. It owns the stack pointer and sequences push (call) and pop (return) requests from the control unit onto a single-port synchronous stack memory. It returns popped return addresses to the fetch stage with a valid strobe, and flags overflow/underflow. It sits between the decode/control unit and the `stackmem` instance.

## Interface
- `IA_WIDTH`, 12, instruction-address width (return address)
- `D_WIDTH`, 34, stack memory word width; return address stored zero-extended in bits [IA_WIDTH-1:0]
- `DEPTH_LOG2`, 4, log2 of stack entries (16 entries)

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, rising edge
- `rst_n_i`  in  1  asynchronous active-low reset
- `push_i`  in  1  call request, carries `push_addr_i`
- `push_addr_i`  in  IA_WIDTH  return address to push
- `pop_i`  in  1  return request
- `clear_i`  in  1  clears sticky errors and leaves ERR
- `ready_o`  out  1  requests accepted this cycle when high
- `ret_addr_o`  out  IA_WIDTH  popped return address
- `ret_valid_o`  out  1  one-cycle strobe, `ret_addr_o` valid
- `depth_o`  out  DEPTH_LOG2+1  current entry count, 0..2^DEPTH_LOG2
- `overflow_o`  out  1  sticky: push attempted when full
- `underflow_o`  out  1  sticky: pop attempted when empty
- `mem_we_o`  out  1  memory write enable
- `mem_addr_o`  out  DEPTH_LOG2  memory address
- `mem_din_o`  out  D_WIDTH  memory write data
- `mem_dout_i`  in  D_WIDTH  memory read data, valid the cycle after the address edge

## Operation
- States: IDLE, POP_WAIT, ERR. `ready_o` = (state == IDLE).
- A request is accepted on a rising edge when `ready_o` is high. `mem_*` outputs are combinational from the request and `sp` so that the memory samples them on the same edge.
- Push only, not full: `mem_we_o`=1, `mem_addr_o`=sp, `mem_din_o`={0, push_addr_i}; sp += 1; stay IDLE.
- Pop only, not empty: `mem_we_o`=0, `mem_addr_o`=sp-1; sp -= 1; go to POP_WAIT.
- POP_WAIT: capture `mem_dout_i[IA_WIDTH-1:0]` into `ret_addr_o`, set `ret_valid_o` for one cycle, go to IDLE.
- Push and pop in the same cycle (tail call), not empty: overwrite top (`mem_addr_o`=sp-1, write); sp unchanged; no `ret_valid_o`.
- Push and pop in the same cycle when empty: treated as a pop on empty.
- Push when full: no write; `overflow_o` set; go to ERR.
- Pop when empty: no read; `underflow_o` set; go to ERR.
- ERR: `ready_o` low and requests ignored. `clear_i` clears both flags and returns to IDLE on the next edge; sp is retained.
- `depth_o` = sp; sp is DEPTH_LOG2+1 bits and never wraps.

## Timing
- Reset values: state IDLE, sp 0, `ret_addr_o` 0, `ret_valid_o` 0, `overflow_o`/`underflow_o` 0, `mem_we_o` 0. `ready_o` is 1 during and after reset.
- Push: single cycle; `depth_o` updates after the accepting edge; back-to-back pushes allowed every cycle.
- Pop accepted at edge N: POP_WAIT during cycle N+1; `ret_valid_o` high for cycle N+2 only; `ready_o` low for cycle N+1 only. Minimum pop-to-pop spacing is 2 cycles.
- Reset asserted mid-operation (POP_WAIT or ERR): state, sp and flags clear immediately; a pending return is discarded; memory contents are not cleared.
- `clear_i` has no effect outside ERR.

## Configuration
- `FSTACK_TOS_CACHE_EN` defined: adds a top-of-stack register that mirrors mem[sp-1].
  - Pushes write both the memory and the cache.
  - A pop accepted at edge N returns the cache value with `ret_valid_o` in cycle N+1, then enters REFILL for one cycle.
  - REFILL reads mem[sp-1] (new sp) into the cache; it is skipped when the new sp is 0.
  - `ready_o` is low in REFILL; pop-to-pop spacing stays 2 cycles.
- Undefined: no cache; pop latency is 2 cycles as above.

## Test plan
- Reset, then push 0x123, 0x456, 0x789 on consecutive cycles -> `depth_o`=3; mem[0..2]=0x123/0x456/0x789; `ret_valid_o` never high.
- Pop twice at legal spacing -> `ret_addr_o`=0x789 then 0x456, each with a one-cycle `ret_valid_o` 2 cycles after acceptance (1 with `FSTACK_TOS_CACHE_EN`); `depth_o`=1.
- Push 16 entries, then a 17th push 0xABC -> `overflow_o`=1, `ready_o`=0, `depth_o`=16, mem[15] unchanged; `clear_i` -> `ready_o`=1, `overflow_o`=0.
- Pop on empty after reset -> `underflow_o`=1, no `ret_valid_o`, `depth_o`=0; further pushes ignored until `clear_i`.
- Depth 2 (0x010, 0x020), push 0x0FF with pop in the same cycle -> depth stays 2; next pop returns 0x0FF, then 0x010.
- Pop accepted, `rst_n_i` low during POP_WAIT -> `ret_valid_o` never asserts; `depth_o`=0, `ready_o`=1 immediately.
